// File: rtl/wb_resolve_stage.sv
// Writeback / branch-resolve stage: holds the MEM bundle, selects write data,
// resolves branches against NZV, tracks HLT and counts retired instructions.
module wb_resolve_stage #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 32,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_branch,
    input  logic [2:0]            in_branch_cond,
    input  logic [2:0]            in_flags,
    input  logic [DATA_W-1:0]     in_pc_plus2,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [DATA_W-1:0]     in_mem_read,
    input  logic                  in_reg_write_src,
    input  logic                  in_reg_write,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_halt,
    output logic                  reg_write_en,
    output logic [REG_ADDR_W-1:0] reg_write_addr,
    output logic [DATA_W-1:0]     reg_write_data,
    output logic                  branching,
    output logic [DATA_W-1:0]     next_pc,
    output logic                  halted,
    output logic [CNT_W-1:0]      retired_count
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state;
    state_t state_next;

    logic                  valid;
    logic                  fresh;
    logic                  branch;
    logic [2:0]            cond;
    logic [2:0]            flags;
    logic [DATA_W-1:0]     pc_plus2;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     mem_read;
    logic                  src;
    logic                  wr;
    logic [REG_ADDR_W-1:0] rd;
    logic                  halt;

    logic                  retire;
    logic                  cond_met;
    logic                  zero_block;
    logic                  flag_n;
    logic                  flag_z;
    logic                  flag_v;

    // Stage register: load on no-stall, fresh marks the first held cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid      <= 1'b0;
            fresh      <= 1'b0;
            branch     <= 1'b0;
            cond       <= '0;
            flags      <= '0;
            pc_plus2   <= '0;
            alu_result <= '0;
            mem_read   <= '0;
            src        <= 1'b0;
            wr         <= 1'b0;
            rd         <= '0;
            halt       <= 1'b0;
        end else begin
            fresh <= ~stall;
            if (!stall) begin
                valid      <= in_valid & ~flush;
                branch     <= in_branch;
                cond       <= in_branch_cond;
                flags      <= in_flags;
                pc_plus2   <= in_pc_plus2;
                alu_result <= in_alu_result;
                mem_read   <= in_mem_read;
                src        <= in_reg_write_src;
                wr         <= in_reg_write;
                rd         <= in_rd;
                halt       <= in_halt;
            end else if (flush) begin
                valid <= 1'b0;
            end
        end
    end

    assign flag_n = flags[2];
    assign flag_z = flags[1];
    assign flag_v = flags[0];

    // Branch condition evaluation against the held NZV flags
    always_comb begin
        cond_met = 1'b0;
        unique case (cond)
            3'b000: cond_met = ~flag_z;
            3'b001: cond_met = flag_z;
            3'b010: cond_met = ~flag_z & ~flag_n;
            3'b011: cond_met = flag_n;
            3'b100: cond_met = flag_z | (~flag_z & ~flag_n);
            3'b101: cond_met = flag_n | flag_z;
            3'b110: cond_met = flag_v;
            3'b111: cond_met = 1'b1;
        endcase
    end

    assign retire     = valid & fresh & (state == RUN);
    assign zero_block = (ZERO_REG != 0) && (rd == '0);

    assign reg_write_data = src ? mem_read : alu_result;
    assign reg_write_addr = rd;
    assign reg_write_en   = retire & wr & ~halt & ~zero_block;
    assign branching      = retire & branch & cond_met;
    assign next_pc        = branching ? alu_result : pc_plus2;
    assign halted         = (state == HALTED);

    // Halt state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Halt next-state: a retiring HLT parks the stage until reset
    always_comb begin
        state_next = state;
        unique case (state)
            RUN:     if (retire && halt) state_next = HALTED;
            HALTED:  state_next = HALTED;
            default: state_next = RUN;
        endcase
    end

    // Saturating retire counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_count <= '0;
        end else if (retire && retired_count != CNT_MAX) begin
            retired_count <= retired_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_wb_resolve_stage.sv
// Bench for wb_resolve_stage: three parameter variants share one stimulus
// stream and are checked every cycle against a behavioural model.
module tb_wb_resolve_stage;

    typedef struct packed {
        logic        valid;
        logic        branch;
        logic [2:0]  cond;
        logic [2:0]  flags;
        logic [15:0] pc2;
        logic [15:0] alu;
        logic [15:0] mem;
        logic        src;
        logic        wr;
        logic [3:0]  rd;
        logic        halt;
    } instr_t;

    logic   clk = 1'b0;
    logic   rst;
    logic   stall;
    logic   flush;
    instr_t cur;

    logic        a_we, b_we, c_we;
    logic [3:0]  a_wa, b_wa, c_wa;
    logic [15:0] a_wd, b_wd, c_wd;
    logic        a_br, b_br, c_br;
    logic [15:0] a_np, b_np, c_np;
    logic        a_h, b_h, c_h;
    logic [31:0] a_cnt, b_cnt;
    logic [1:0]  c_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_resolve_stage u_main (
        .clk(clk), .rst(rst), .in_valid(cur.valid), .stall(stall),
        .flush(flush), .in_branch(cur.branch), .in_branch_cond(cur.cond),
        .in_flags(cur.flags), .in_pc_plus2(cur.pc2),
        .in_alu_result(cur.alu), .in_mem_read(cur.mem),
        .in_reg_write_src(cur.src), .in_reg_write(cur.wr),
        .in_rd(cur.rd), .in_halt(cur.halt),
        .reg_write_en(a_we), .reg_write_addr(a_wa),
        .reg_write_data(a_wd), .branching(a_br), .next_pc(a_np),
        .halted(a_h), .retired_count(a_cnt)
    );

    wb_resolve_stage #(.ZERO_REG(0)) u_zr0 (
        .clk(clk), .rst(rst), .in_valid(cur.valid), .stall(stall),
        .flush(flush), .in_branch(cur.branch), .in_branch_cond(cur.cond),
        .in_flags(cur.flags), .in_pc_plus2(cur.pc2),
        .in_alu_result(cur.alu), .in_mem_read(cur.mem),
        .in_reg_write_src(cur.src), .in_reg_write(cur.wr),
        .in_rd(cur.rd), .in_halt(cur.halt),
        .reg_write_en(b_we), .reg_write_addr(b_wa),
        .reg_write_data(b_wd), .branching(b_br), .next_pc(b_np),
        .halted(b_h), .retired_count(b_cnt)
    );

    wb_resolve_stage #(.CNT_W(2)) u_c2 (
        .clk(clk), .rst(rst), .in_valid(cur.valid), .stall(stall),
        .flush(flush), .in_branch(cur.branch), .in_branch_cond(cur.cond),
        .in_flags(cur.flags), .in_pc_plus2(cur.pc2),
        .in_alu_result(cur.alu), .in_mem_read(cur.mem),
        .in_reg_write_src(cur.src), .in_reg_write(cur.wr),
        .in_rd(cur.rd), .in_halt(cur.halt),
        .reg_write_en(c_we), .reg_write_addr(c_wa),
        .reg_write_data(c_wd), .branching(c_br), .next_pc(c_np),
        .halted(c_h), .retired_count(c_cnt)
    );

    // Model: the most recently loaded instruction, whether it still owes
    // its single retirement, the halt latch and an unbounded retire tally.
    instr_t m_e;
    logic   m_new;
    logic   m_halted;
    int     m_total;

    function automatic logic cond_ok(input logic [2:0] c, input logic [2:0] f);
        logic n, z, v;
        n = f[2];
        z = f[1];
        v = f[0];
        case (c)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return z || (!z && !n);
            3'd5:    return n || z;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_e      <= '0;
            m_new    <= 1'b0;
            m_halted <= 1'b0;
            m_total  <= 0;
        end else begin
            if (m_new && !m_halted) begin
                m_total <= m_total + 1;
                if (m_e.halt) m_halted <= 1'b1;
            end
            if (!stall) begin
                m_e   <= cur;
                m_new <= cur.valid & ~flush;
            end else begin
                m_new <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of all three variants against the model
    always @(negedge clk) begin
        logic        ret, brn, we_nz, we_any;
        logic [15:0] d, np;
        int          sat;
        ret    = m_new && !m_halted;
        brn    = ret && m_e.branch && cond_ok(m_e.cond, m_e.flags);
        we_any = ret && m_e.wr && !m_e.halt;
        we_nz  = we_any && (m_e.rd != 4'd0);
        d      = m_e.src ? m_e.mem : m_e.alu;
        np     = brn ? m_e.alu : m_e.pc2;
        sat    = (m_total > 3) ? 3 : m_total;
        chk("main.we", 32'(a_we), 32'(we_nz));
        chk("main.wa", 32'(a_wa), 32'(m_e.rd));
        chk("main.wd", 32'(a_wd), 32'(d));
        chk("main.br", 32'(a_br), 32'(brn));
        chk("main.np", 32'(a_np), 32'(np));
        chk("main.halted", 32'(a_h), 32'(m_halted));
        chk("main.cnt", a_cnt, 32'(m_total));
        chk("zr0.we", 32'(b_we), 32'(we_any));
        chk("zr0.cnt", b_cnt, 32'(m_total));
        chk("c2.we", 32'(c_we), 32'(we_nz));
        chk("c2.cnt", 32'(c_cnt), 32'(sat));
        chk("c2.br", 32'(c_br), 32'(brn));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put_wr(input logic [3:0] rd, input logic [15:0] alu,
                          input logic [15:0] mem, input logic src);
        cur       = '0;
        cur.valid = 1'b1;
        cur.wr    = 1'b1;
        cur.rd    = rd;
        cur.alu   = alu;
        cur.mem   = mem;
        cur.src   = src;
        cur.pc2   = 16'h0002;
    endtask

    task automatic bubble();
        cur = '0;
    endtask

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        cur   = '0;
        repeat (3) cyc();
        chk("rst.we", 32'(a_we), 32'd0);
        chk("rst.np", 32'(a_np), 32'd0);
        chk("rst.cnt", a_cnt, 32'd0);
        rst = 1'b0;
        cyc();

        put_wr(4'd3, 16'h1234, 16'hBEEF, 1'b0);
        cyc();
        chk("add.we", 32'(a_we), 32'd1);
        chk("add.wd", 32'(a_wd), 32'h1234);
        chk("add.wa", 32'(a_wa), 32'd3);
        put_wr(4'd5, 16'h1234, 16'hBEEF, 1'b1);
        cyc();
        chk("ld.we", 32'(a_we), 32'd1);
        chk("ld.wd", 32'(a_wd), 32'hBEEF);
        bubble();
        cyc();
        chk("ld.cnt", a_cnt, 32'd2);

        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                cur        = '0;
                cur.valid  = 1'b1;
                cur.branch = 1'b1;
                cur.cond   = 3'(c);
                cur.flags  = 3'(f);
                cur.alu    = 16'h0040;
                cur.pc2    = 16'h0012;
                cyc();
                if (c == 2 && f == 0) begin
                    chk("b010f000.br", 32'(a_br), 32'd1);
                    chk("b010f000.np", 32'(a_np), 32'h0040);
                end
                if (c == 2 && f == 4) begin
                    chk("b010f100.br", 32'(a_br), 32'd0);
                    chk("b010f100.np", 32'(a_np), 32'h0012);
                end
            end
        end
        bubble();
        cyc();
        chk("sweep.cnt", a_cnt, 32'd66);

        put_wr(4'd2, 16'h2222, 16'h0000, 1'b0);
        cyc();
        chk("stall.first", 32'(a_we), 32'd1);
        stall = 1'b1;
        repeat (3) begin
            cyc();
            chk("stall.hold", 32'(a_we), 32'd0);
        end
        stall = 1'b0;
        bubble();
        cyc();
        chk("stall.cnt", a_cnt, 32'd67);

        put_wr(4'd7, 16'h7777, 16'h0000, 1'b0);
        flush = 1'b1;
        cyc();
        chk("flush.we", 32'(a_we), 32'd0);
        flush = 1'b0;
        put_wr(4'd6, 16'h6666, 16'h0000, 1'b0);
        cyc();
        stall = 1'b1;
        flush = 1'b1;
        cyc();
        chk("sflush.we", 32'(a_we), 32'd0);
        flush = 1'b0;
        cyc();
        chk("sflush.hold", 32'(a_we), 32'd0);
        stall = 1'b0;
        bubble();
        cyc();
        chk("sflush.cnt", a_cnt, 32'd68);

        put_wr(4'd0, 16'h0F0F, 16'h0000, 1'b0);
        cyc();
        chk("zr1.we", 32'(a_we), 32'd0);
        chk("zr0.we", 32'(b_we), 32'd1);
        bubble();
        cyc();
        chk("zr.cnt", a_cnt, 32'd69);

        put_wr(4'd4, 16'h4444, 16'h0000, 1'b0);
        cyc();
        #1 rst = 1'b1;
        #1;
        chk("mrst.we", 32'(a_we), 32'd0);
        chk("mrst.wd", 32'(a_wd), 32'd0);
        chk("mrst.cnt", a_cnt, 32'd0);
        bubble();
        cyc();
        rst = 1'b0;
        cyc();
        chk("mrst.cnt2", a_cnt, 32'd0);

        put_wr(4'd1, 16'h0101, 16'h0000, 1'b0);
        repeat (5) cyc();
        bubble();
        cyc();
        chk("sat.c2", 32'(c_cnt), 32'd3);
        chk("sat.main", a_cnt, 32'd5);

        cur        = '0;
        cur.valid  = 1'b1;
        cur.halt   = 1'b1;
        cur.branch = 1'b1;
        cur.cond   = 3'b111;
        cur.wr     = 1'b1;
        cur.rd     = 4'd8;
        cur.alu    = 16'h0100;
        cur.pc2    = 16'h0050;
        cyc();
        chk("hlt.br", 32'(a_br), 32'd1);
        chk("hlt.np", 32'(a_np), 32'h0100);
        chk("hlt.we", 32'(a_we), 32'd0);
        chk("hlt.h0", 32'(a_h), 32'd0);
        put_wr(4'd9, 16'h9999, 16'h0000, 1'b0);
        cyc();
        chk("hlt.h1", 32'(a_h), 32'd1);
        chk("hlt.we2", 32'(a_we), 32'd0);
        repeat (3) cyc();
        chk("hlt.cnt", a_cnt, 32'd6);
        bubble();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
